// File: rtl/key_input_ctrl_pkg.sv
// Shared constants, types and keycode helper for the key input controller.
package key_input_ctrl_pkg;

  // Default keycodes (USB HID usage IDs).
  localparam logic [7:0] KC_LEFT  = 8'h04;  // A
  localparam logic [7:0] KC_DOWN  = 8'h16;  // S
  localparam logic [7:0] KC_RIGHT = 8'h07;  // D
  localparam logic [7:0] KC_ROTL  = 8'h0D;  // J
  localparam logic [7:0] KC_HARD  = 8'h0E;  // K
  localparam logic [7:0] KC_ROTR  = 8'h0F;  // L

  // Default frame timings.
  localparam int DAS_FRAMES_DEF  = 10;
  localparam int ARR_FRAMES_DEF  = 2;
  localparam int SOFT_FRAMES_DEF = 3;

  // Bit positions inside keys_held / the action vector.
  localparam int IDX_LEFT  = 0;
  localparam int IDX_RIGHT = 1;
  localparam int IDX_DOWN  = 2;
  localparam int IDX_ROTL  = 3;
  localparam int IDX_ROTR  = 4;
  localparam int IDX_HARD  = 5;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_DELAY  = 2'd1,
    H_REPEAT = 2'd2
  } h_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } hdir_t;

  // True when any of the four keycode slots carries the given code.
  function automatic logic key_hit(input logic [31:0] word, input logic [7:0] code);
    return (word[31:24] == code) | (word[23:16] == code) |
           (word[15:8]  == code) | (word[7:0]   == code);
  endfunction

endpackage

// File: rtl/key_input_ctrl_repeat_timer.sv
// Frame-step repeat timer: fires on the first step after arming (or on a
// restart), then again every time the down-counter expires.
module key_input_ctrl_repeat_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear_i,    // disarm and zero the counter
  input  logic       step_i,     // one frame tick while the action is requested
  input  logic       restart_i,  // fire now and reload the initial delay
  input  logic [5:0] load_i,     // frames from first fire to first repeat
  input  logic [5:0] period_i,   // frames between repeats
  output logic       fire_o      // combinational, only during step_i
);

  logic [5:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;

  // Next counter/arming state and fire decision for this step.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    fire_o  = 1'b0;
    if (clear_i) begin
      cnt_d   = 6'd0;
      armed_d = 1'b0;
    end else if (step_i) begin
      if (restart_i || !armed_q) begin
        fire_o  = 1'b1;
        cnt_d   = load_i - 6'd1;
        armed_d = 1'b1;
      end else if (cnt_q == 6'd0) begin
        fire_o = 1'b1;
        cnt_d  = period_i - 6'd1;
      end else begin
        cnt_d = cnt_q - 6'd1;
      end
    end
  end

  // Counter and arming registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= 6'd0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/key_input_ctrl.sv
// Keycode word to frame-aligned one-Clk game action pulses: press edges,
// DAS/ARR horizontal auto-shift, fixed-rate soft drop, one-shot rotate and
// hard drop.
module key_input_ctrl
  import key_input_ctrl_pkg::*;
#(
  parameter logic [7:0] KEY_LEFT    = KC_LEFT,
  parameter logic [7:0] KEY_DOWN    = KC_DOWN,
  parameter logic [7:0] KEY_RIGHT   = KC_RIGHT,
  parameter logic [7:0] KEY_ROTL    = KC_ROTL,
  parameter logic [7:0] KEY_HARD    = KC_HARD,
  parameter logic [7:0] KEY_ROTR    = KC_ROTR,
  parameter int         DAS_FRAMES  = DAS_FRAMES_DEF,
  parameter int         ARR_FRAMES  = ARR_FRAMES_DEF,
  parameter int         SOFT_FRAMES = SOFT_FRAMES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [31:0] keycode,
  input  logic        enable,
  output logic        move_left,
  output logic        move_right,
  output logic        soft_drop,
  output logic        rotate_left,
  output logic        rotate_right,
  output logic        hard_drop,
  output logic [5:0]  keys_held
);

  // Tick pipeline.
  logic frame_d_q;
  logic tick_q;

  // Key state: raw held flags, value at the previous tick, and keys that were
  // already down while disabled (ignored until released).
  logic [5:0] held_d, held_q;
  logic [5:0] prev_held_q;
  logic [5:0] lock_d, lock_q;
  logic [5:0] eff_held;
  logic [5:0] pressed;

  // Horizontal FSM.
  h_state_t h_state_d, h_state_q;
  hdir_t    cur_dir_d, cur_dir_q;
  hdir_t    dir;
  logic     h_clear, h_step, h_restart, h_fire;

  // Soft drop.
  logic     s_clear, s_step, s_fire;

  // Registered action vector {hard, rotr, rotl, soft, right, left}.
  logic [5:0] act_d, act_q;
  logic       frame_ok, hard_now, act_ok;

  // Decode the four slots into per-action held flags.
  always_comb begin
    held_d            = 6'd0;
    held_d[IDX_LEFT]  = key_hit(keycode, KEY_LEFT);
    held_d[IDX_RIGHT] = key_hit(keycode, KEY_RIGHT);
    held_d[IDX_DOWN]  = key_hit(keycode, KEY_DOWN);
    held_d[IDX_ROTL]  = key_hit(keycode, KEY_ROTL);
    held_d[IDX_ROTR]  = key_hit(keycode, KEY_ROTR);
    held_d[IDX_HARD]  = key_hit(keycode, KEY_HARD);
  end

  // Keys held while disabled stay locked until released after enabling.
  always_comb begin
    lock_d   = enable ? (lock_q & held_q) : held_q;
    eff_held = held_q & ~lock_q;
    pressed  = eff_held & ~prev_held_q;
  end

  // Resolve the requested horizontal direction; opposing keys cancel.
  always_comb begin
    dir = NONE;
    if (eff_held[IDX_LEFT] && !eff_held[IDX_RIGHT]) begin
      dir = LEFT;
    end else if (eff_held[IDX_RIGHT] && !eff_held[IDX_LEFT]) begin
      dir = RIGHT;
    end
  end

  // Horizontal timer controls: restart on direction change, clear on release.
  always_comb begin
    h_step    = tick_q & enable & (dir != NONE);
    h_clear   = ~enable | (tick_q & (dir == NONE));
    h_restart = (h_state_q != H_IDLE) & (dir != cur_dir_q);
    s_step    = tick_q & enable & eff_held[IDX_DOWN];
    s_clear   = ~enable | ~eff_held[IDX_DOWN];
  end

  key_input_ctrl_repeat_timer u_h_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear_i   (h_clear),
    .step_i    (h_step),
    .restart_i (h_restart),
    .load_i    (6'(DAS_FRAMES)),
    .period_i  (6'(ARR_FRAMES)),
    .fire_o    (h_fire)
  );

  key_input_ctrl_repeat_timer u_s_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear_i   (s_clear),
    .step_i    (s_step),
    .restart_i (1'b0),
    .load_i    (6'(SOFT_FRAMES)),
    .period_i  (6'(SOFT_FRAMES)),
    .fire_o    (s_fire)
  );

  // Horizontal FSM next state; a fire in H_DELAY without a direction change
  // is the DAS expiry and moves on to auto-repeat.
  always_comb begin
    h_state_d = h_state_q;
    cur_dir_d = cur_dir_q;
    if (!enable) begin
      h_state_d = H_IDLE;
      cur_dir_d = NONE;
    end else if (tick_q) begin
      case (h_state_q)
        H_IDLE: begin
          if (dir != NONE) begin
            h_state_d = H_DELAY;
            cur_dir_d = dir;
          end
        end
        H_DELAY, H_REPEAT: begin
          if (dir == NONE) begin
            h_state_d = H_IDLE;
            cur_dir_d = NONE;
          end else if (dir != cur_dir_q) begin
            h_state_d = H_DELAY;
            cur_dir_d = dir;
          end else if (h_fire) begin
            h_state_d = H_REPEAT;
          end
        end
        default: begin
          h_state_d = H_IDLE;
          cur_dir_d = NONE;
        end
      endcase
    end
  end

  // Action pulses for this tick; a hard drop masks every other action.
  always_comb begin
    frame_ok        = tick_q & enable;
    hard_now        = frame_ok & pressed[IDX_HARD];
    act_ok          = frame_ok & ~pressed[IDX_HARD];
    act_d           = 6'd0;
    act_d[IDX_LEFT]  = act_ok & h_fire & (dir == LEFT);
    act_d[IDX_RIGHT] = act_ok & h_fire & (dir == RIGHT);
    act_d[IDX_DOWN]  = act_ok & s_fire;
    act_d[IDX_ROTL]  = act_ok & pressed[IDX_ROTL] & ~pressed[IDX_ROTR];
    act_d[IDX_ROTR]  = act_ok & pressed[IDX_ROTR] & ~pressed[IDX_ROTL];
    act_d[IDX_HARD]  = hard_now;
  end

  // All state registers; prev_held follows held keys on every tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d_q   <= 1'b0;
      tick_q      <= 1'b0;
      held_q      <= 6'd0;
      prev_held_q <= 6'd0;
      lock_q      <= 6'd0;
      h_state_q   <= H_IDLE;
      cur_dir_q   <= NONE;
      act_q       <= 6'd0;
    end else begin
      frame_d_q <= frame_clk;
      tick_q    <= frame_clk & ~frame_d_q;
      held_q    <= held_d;
      lock_q    <= lock_d;
      if (tick_q) begin
        prev_held_q <= held_q;
      end
      h_state_q <= h_state_d;
      cur_dir_q <= cur_dir_d;
      act_q     <= act_d;
    end
  end

  assign move_left    = act_q[IDX_LEFT];
  assign move_right   = act_q[IDX_RIGHT];
  assign soft_drop    = act_q[IDX_DOWN];
  assign rotate_left  = act_q[IDX_ROTL];
  assign rotate_right = act_q[IDX_ROTR];
  assign hard_drop    = act_q[IDX_HARD];
  assign keys_held    = held_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Bench for key_input_ctrl: one frame per vector, pulses collected over the
// whole frame window, plus reset-abort and reset-value sequences.
module tb_key_input_ctrl;
  import key_input_ctrl_pkg::*;

  // Clock/reset and DUT signals.
  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [31:0] keycode;
  logic        enable;
  logic        move_left, move_right, soft_drop;
  logic        rotate_left, rotate_right, hard_drop;
  logic [5:0]  keys_held;

  always #10 Clk = ~Clk;

  key_input_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .enable       (enable),
    .move_left    (move_left),
    .move_right   (move_right),
    .soft_drop    (soft_drop),
    .rotate_left  (rotate_left),
    .rotate_right (rotate_right),
    .hard_drop    (hard_drop),
    .keys_held    (keys_held)
  );

  // Action bits {hard, rotr, rotl, soft, right, left}.
  localparam logic [5:0] P_L  = 6'b000001;
  localparam logic [5:0] P_R  = 6'b000010;
  localparam logic [5:0] P_S  = 6'b000100;
  localparam logic [5:0] P_RL = 6'b001000;
  localparam logic [5:0] P_RR = 6'b010000;
  localparam logic [5:0] P_H  = 6'b100000;

  typedef struct {
    logic [31:0] key;
    logic        en;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [5:0] outs_now();
    return {hard_drop, rotate_right, rotate_left, soft_drop, move_right, move_left};
  endfunction

  // Independent model of the held-flag decode.
  function automatic logic [5:0] held_model(input logic [31:0] k);
    logic [5:0] h;
    h = 6'd0;
    for (int s = 0; s < 4; s++) begin
      case (k[s*8 +: 8])
        8'h04: h[0] = 1'b1;
        8'h07: h[1] = 1'b1;
        8'h16: h[2] = 1'b1;
        8'h0D: h[3] = 1'b1;
        8'h0F: h[4] = 1'b1;
        8'h0E: h[5] = 1'b1;
        default: ;
      endcase
    end
    return h;
  endfunction

  function automatic void add(input logic [31:0] k, input logic e, input logic [5:0] x);
    vec_t v;
    v.key = k;
    v.en  = e;
    v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One frame strobe; records which outputs pulsed and the longest pulse.
  task automatic run_frame(output logic [5:0] seen, output int maxw);
    int cnt[6];
    logic [5:0] o;
    for (int b = 0; b < 6; b++) cnt[b] = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (k == 3) frame_clk = 1'b0;
      o = outs_now();
      for (int b = 0; b < 6; b++) if (o[b]) cnt[b]++;
    end
    seen = 6'd0;
    maxw = 0;
    for (int b = 0; b < 6; b++) begin
      if (cnt[b] > 0) seen[b] = 1'b1;
      if (cnt[b] > maxw) maxw = cnt[b];
    end
  endtask

  initial begin
    logic [5:0] seen;
    int         maxw;

    // Reset with keys down: everything must read zero.
    Reset     = 1'b1;
    frame_clk = 1'b0;
    enable    = 1'b1;
    keycode   = 32'h0000_0004;
    repeat (4) @(negedge Clk);
    check("reset_outputs", outs_now(), 6'd0);
    check("reset_keys_held", keys_held, 6'd0);
    check("reset_state", 6'(dut.h_state_q), 6'(H_IDLE));
    keycode = 32'h0;
    Reset   = 1'b0;
    repeat (2) @(negedge Clk);

    // Vector table.
    for (int i = 1; i <= 15; i++)
      add(32'h0000_0004, 1'b1, (i == 1 || i == 11 || i == 13 || i == 15) ? P_L : 6'd0);
    add(32'h0, 1'b1, 6'd0);
    for (int i = 0; i < 4; i++) add(32'h0000_0704, 1'b1, 6'd0);
    for (int i = 0; i < 11; i++)
      add(32'h0000_0007, 1'b1, (i == 0 || i == 10) ? P_R : 6'd0);
    add(32'h0, 1'b1, 6'd0);
    for (int i = 0; i < 20; i++) add(32'h0000_000D, 1'b1, (i == 0) ? P_RL : 6'd0);
    add(32'h0, 1'b1, 6'd0);
    for (int i = 0; i < 3; i++) add(32'h0000_0F0D, 1'b1, 6'd0);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0000_000F, 1'b1, P_RR);
    add(32'h0000_000F, 1'b1, 6'd0);
    add(32'h0, 1'b1, 6'd0);
    for (int i = 1; i <= 7; i++)
      add(32'h0000_0016, 1'b1, (i == 1 || i == 4 || i == 7) ? P_S : 6'd0);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0000_0016, 1'b1, P_S);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0E00_0704, 1'b1, P_H);
    add(32'h0E00_0704, 1'b1, 6'd0);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0E00_0016, 1'b1, P_H);
    add(32'h0E00_0016, 1'b1, 6'd0);
    add(32'h0E00_0016, 1'b1, 6'd0);
    add(32'h0E00_0016, 1'b1, P_S);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0404_0404, 1'b1, P_L);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0000_0004, 1'b1, P_L);
    add(32'h0000_0007, 1'b1, P_R);
    for (int i = 0; i < 10; i++) add(32'h0000_0007, 1'b1, (i == 9) ? P_R : 6'd0);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0000_0004, 1'b0, 6'd0);
    add(32'h0000_0004, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) add(32'h0000_0004, 1'b1, 6'd0);
    add(32'h0, 1'b1, 6'd0);
    add(32'h0000_0004, 1'b1, P_L);
    add(32'h0, 1'b1, 6'd0);

    foreach (vecs[i]) begin
      keycode = vecs[i].key;
      enable  = vecs[i].en;
      run_frame(seen, maxw);
      check($sformatf("vec%0d_pulses", i), seen, vecs[i].exp);
      check($sformatf("vec%0d_width", i), 6'(maxw), (vecs[i].exp != 6'd0) ? 6'd1 : 6'd0);
      check($sformatf("vec%0d_held", i), keys_held, held_model(vecs[i].key));
    end

    // Reset in the middle of auto-repeat.
    enable  = 1'b1;
    keycode = 32'h0000_0004;
    for (int f = 1; f <= 12; f++) begin
      run_frame(seen, maxw);
      check($sformatf("arr_frame%0d", f), seen, (f == 1 || f == 11) ? P_L : 6'd0);
    end
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_abort_outputs", outs_now(), 6'd0);
    check("rst_abort_state", 6'(dut.h_state_q), 6'(H_IDLE));
    Reset     = 1'b0;
    frame_clk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check($sformatf("post_rst_quiet%0d", k), outs_now(), 6'd0);
    end
    run_frame(seen, maxw);
    check("post_rst_first", seen, P_L);
    run_frame(seen, maxw);
    check("post_rst_das", seen, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
